// File: rtl/bus_lectura_pkg.sv
// Shared types and helpers for the parametrised read-bus driver.
package bus_lectura_pkg;

   // Read FSM: accept request, wait for the selected slave, report completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Data returned to the processor on an unmapped or timed-out read.
   localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0000;

   // Widest packed table and widest single entry the slice helper handles.
   localparam int MAP_W = 1024;
   localparam int ENT_W = 64;

   // Pull entry k (w bits wide) out of a packed table; bits beyond w read as 0.
   function automatic logic [ENT_W-1:0] slice(input logic [MAP_W-1:0] map,
                                              input int k, input int w);
      logic [ENT_W-1:0] r;
      r = '0;
      for (int b = 0; b < ENT_W; b++)
         if (b < w && (k * w + b) < MAP_W) r[b] = map[k * w + b];
      return r;
   endfunction

endpackage

// File: rtl/bus_lectura_decod.sv
// Address decoder: base/mask compare per slave, lowest index wins on overlap.
module bus_lectura_decod
   import bus_lectura_pkg::*;
#(
   parameter int                    N_SLV    = 4,
   parameter int                    AW       = 32,
   parameter logic [N_SLV*AW-1:0]   BASE_MAP = {32'h3000, 32'h2004, 32'h2000, 32'h1000},
   parameter logic [N_SLV*AW-1:0]   MASK_MAP = {32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFC00},
   parameter int                    SW       = (N_SLV > 1) ? $clog2(N_SLV) : 1
)(
   input  logic [AW-1:0]   address_i,
   output logic            hit_o,
   output logic [SW-1:0]   sel_idx_o
);

   // Tables widened to the helper's fixed width so the slice function can index them.
   localparam logic [MAP_W-1:0] BMAP = MAP_W'(BASE_MAP);
   localparam logic [MAP_W-1:0] MMAP = MAP_W'(MASK_MAP);

   logic [N_SLV-1:0] hit_vec;
   logic [AW-1:0]    base_k;
   logic [AW-1:0]    mask_k;

   // Per-slave match: address and base agree on every bit the mask keeps.
   always_comb begin
      hit_vec = '0;
      base_k  = '0;
      mask_k  = '0;
      for (int k = 0; k < N_SLV; k++) begin
         base_k     = AW'(slice(BMAP, k, AW));
         mask_k     = AW'(slice(MMAP, k, AW));
         hit_vec[k] = ((address_i & mask_k) == (base_k & mask_k));
      end
   end

   // Priority encoder: scan downwards so the lowest matching index is the last write.
   always_comb begin
      hit_o     = 1'b0;
      sel_idx_o = '0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if (hit_vec[k]) begin
            hit_o     = 1'b1;
            sel_idx_o = SW'(k);
         end
      end
   end

endmodule

// File: rtl/bus_lectura_param.sv
// Registered read-bus driver: decodes the load address, selects one slave for
// a single cycle, waits for its ack (bounded by TIMEOUT) and returns data or
// an error with a one-cycle ready pulse. Error completions are counted.
module bus_lectura_param
   import bus_lectura_pkg::*;
#(
   parameter int                    N_SLV    = 4,
   parameter int                    AW       = 32,
   parameter int                    DW       = 32,
   parameter logic [N_SLV*AW-1:0]   BASE_MAP = {32'h3000, 32'h2004, 32'h2000, 32'h1000},
   parameter logic [N_SLV*AW-1:0]   MASK_MAP = {32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFC00},
   parameter int                    TIMEOUT  = 15,
   parameter logic [DW-1:0]         ERR_DATA = DW'(ERR_DATA_DEF)
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  rd_req_i,
   input  logic [AW-1:0]         address_i,
   input  logic [N_SLV*DW-1:0]   slv_data_i,
   input  logic [N_SLV-1:0]      slv_ack_i,
   output logic [N_SLV-1:0]      slv_sel_o,
   output logic [DW-1:0]         d_o,
   output logic                  ready_o,
   output logic                  err_o,
   output logic [15:0]           err_cnt_o
);

   localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                    state_q, state_d;
   logic [SW-1:0]             sel_q;
   logic [CW-1:0]             cnt_q;
   logic                      hit;
   logic [SW-1:0]             hit_idx;
   logic                      ack_sel;
   logic                      tmo;
   logic [N_SLV-1:0][DW-1:0]  sd;

   // Next-cycle values for the registered outputs and datapath strobes.
   logic [N_SLV-1:0]          sel_d;
   logic                      ready_d;
   logic                      err_d;
   logic                      load;
   logic                      cap_data;
   logic                      cap_err;

   bus_lectura_decod #(
      .N_SLV    (N_SLV),
      .AW       (AW),
      .BASE_MAP (BASE_MAP),
      .MASK_MAP (MASK_MAP),
      .SW       (SW)
   ) u_decod (
      .address_i (address_i),
      .hit_o     (hit),
      .sel_idx_o (hit_idx)
   );

   assign sd      = slv_data_i;
   // Only the latched slave may complete the read; other acks are ignored.
   assign ack_sel = slv_ack_i[sel_q];
   assign tmo     = (cnt_q == '0);

   // State register; reset abandons any read in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state: requests are only looked at in IDLE; DONE lasts one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rd_req_i) state_d = hit ? WAIT : DONE;
         WAIT:    if (ack_sel || tmo) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: an ack wins over a counter that has just reached zero.
   always_comb begin
      sel_d    = '0;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      load     = 1'b0;
      cap_data = 1'b0;
      cap_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_req_i) begin
               if (hit) begin
                  load           = 1'b1;
                  sel_d[hit_idx] = 1'b1;
               end else begin
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  cap_err = 1'b1;
               end
            end
         end
         WAIT: begin
            if (ack_sel) begin
               ready_d  = 1'b1;
               cap_data = 1'b1;
            end else if (tmo) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               cap_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Select pulse and completion flags; all registered so they last one cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slv_sel_o <= '0;
         ready_o   <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         slv_sel_o <= sel_d;
         ready_o   <= ready_d;
         err_o     <= err_d;
      end
   end

   // Latch the winning slave and run the wait budget down while in WAIT.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sel_q <= hit_idx;
         cnt_q <= CW'(TIMEOUT);
      end else if (state_q == WAIT && !tmo) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Read data only moves on entry to DONE, otherwise it holds the last result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      d_o <= '0;
      else if (cap_data) d_o <= sd[sel_q];
      else if (cap_err)  d_o <= ERR_DATA;
   end

   // Saturating count of error completions.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                             err_cnt_o <= '0;
      else if (cap_err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
   end

endmodule

// File: tb/tb_bus_lectura_param.sv
// Directed bench for bus_lectura_param with the default 4-slave map.
module tb_bus_lectura_param;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b0;
   logic              rd_req = 1'b0;
   logic [31:0]       addr   = '0;
   logic [3:0][31:0]  sdata  = '0;
   logic [3:0]        sack   = '0;
   logic [3:0]        sel;
   logic [31:0]       d;
   logic              rdy;
   logic              err;
   logic [15:0]       ecnt;

   int n_chk  = 0;
   int n_fail = 0;
   int lat;
   logic [3:0] sel1;
   logic rdy_seen;

   always #5 clk = ~clk;

   bus_lectura_param dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .rd_req_i   (rd_req),
      .address_i  (addr),
      .slv_data_i (sdata),
      .slv_ack_i  (sack),
      .slv_sel_o  (sel),
      .d_o        (d),
      .ready_o    (rdy),
      .err_o      (err),
      .err_cnt_o  (ecnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One unmapped read: request in cycle 0, completion in cycle 1.
   task automatic unmapped_read();
      rd_req = 1'b1;
      addr   = 32'h0000_1400;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_sel",  32'(sel),  32'h0);
      chk("rst_d",    d,         32'h0);
      chk("rst_rdy",  32'(rdy),  32'h0);
      chk("rst_err",  32'(err),  32'h0);
      chk("rst_ecnt", 32'(ecnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: zero-latency slave0
      rd_req = 1'b1; addr = 32'h0000_1004; sdata[0] = 32'hCAFE_BABE;
      @(negedge clk);
      chk("t1_sel_c1", 32'(sel), 32'h1);
      chk("t1_rdy_c1", 32'(rdy), 32'h0);
      sack = 4'b0001;
      @(negedge clk);
      chk("t1_rdy_c2", 32'(rdy), 32'h1);
      chk("t1_err_c2", 32'(err), 32'h0);
      chk("t1_d_c2",   d,        32'hCAFE_BABE);
      chk("t1_sel_c2", 32'(sel), 32'h0);
      rd_req = 1'b0; sack = '0;
      @(negedge clk);
      chk("t1_rdy_c3", 32'(rdy), 32'h0);
      chk("t1_d_hold", d,        32'hCAFE_BABE);

      // 2: slave2 acks three cycles after select, slave1 acks spuriously
      rd_req = 1'b1; addr = 32'h0000_2004; sdata[2] = 32'h0000_005A; sdata[1] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t2_sel_c1", 32'(sel), 32'h4);
      sack = 4'b0010;
      @(negedge clk);
      chk("t2_rdy_c2", 32'(rdy), 32'h0);
      chk("t2_sel_c2", 32'(sel), 32'h0);
      @(negedge clk);
      chk("t2_rdy_c3", 32'(rdy), 32'h0);
      sack = 4'b0000;
      @(negedge clk);
      chk("t2_rdy_c4", 32'(rdy), 32'h0);
      sack = 4'b0100;
      @(negedge clk);
      chk("t2_rdy_c5", 32'(rdy), 32'h1);
      chk("t2_err_c5", 32'(err), 32'h0);
      chk("t2_d_c5",   d,        32'h0000_005A);
      rd_req = 1'b0; sack = '0;
      @(negedge clk);

      // 3: unmapped address
      rd_req = 1'b1; addr = 32'h0000_1400;
      @(negedge clk);
      chk("t3_rdy_c1",  32'(rdy),  32'h1);
      chk("t3_err_c1",  32'(err),  32'h1);
      chk("t3_d_c1",    d,         32'h0);
      chk("t3_sel_c1",  32'(sel),  32'h0);
      chk("t3_ecnt_c1", 32'(ecnt), 32'h1);
      rd_req = 1'b0;
      @(negedge clk);
      chk("t3_rdy_c2", 32'(rdy), 32'h0);
      chk("t3_err_c2", 32'(err), 32'h0);

      // 4: slave3 never acks -> timeout
      rd_req = 1'b1; addr = 32'h0000_3010; sdata[3] = 32'h0000_0077;
      sel1 = '0; lat = 0; rdy_seen = 1'b0;
      for (int i = 1; i <= 40 && !rdy_seen; i++) begin
         @(negedge clk);
         if (i == 1) sel1 = sel;
         if (rdy) begin rdy_seen = 1'b1; lat = i; end
      end
      chk("t4_sel_c1", 32'(sel1), 32'h8);
      chk("t4_lat",    lat,       32'd17);
      chk("t4_err",    32'(err),  32'h1);
      chk("t4_d",      d,         32'h0);
      chk("t4_ecnt",   32'(ecnt), 32'h2);
      rd_req = 1'b0;
      @(negedge clk);

      // 4b: error counter saturation, started near the top of its range
      force dut.err_cnt_o = 16'hFFFD;
      rd_req = 1'b1; addr = 32'h0000_1400;
      @(negedge clk);
      rd_req = 1'b0;
      release dut.err_cnt_o;
      @(negedge clk);
      unmapped_read();
      unmapped_read();
      unmapped_read();
      chk("t4_sat", 32'(ecnt), 32'hFFFF);
      unmapped_read();
      chk("t4_sat_hold", 32'(ecnt), 32'hFFFF);

      // 4c: ack in the cycle the counter reaches zero still succeeds
      rd_req = 1'b1; addr = 32'h0000_3010;
      lat = 0; rdy_seen = 1'b0;
      for (int i = 1; i <= 40 && !rdy_seen; i++) begin
         @(negedge clk);
         if (rdy) begin rdy_seen = 1'b1; lat = i; end
         sack = (i == 16) ? 4'b1000 : 4'b0000;
      end
      chk("t4c_lat", lat,      32'd17);
      chk("t4c_err", 32'(err), 32'h0);
      chk("t4c_d",   d,        32'h0000_0077);
      rd_req = 1'b0; sack = '0;
      @(negedge clk);

      // 5: reset during WAIT aborts the read
      rd_req = 1'b1; addr = 32'h0000_2004; sdata[2] = 32'h0000_00A5;
      @(negedge clk);
      chk("t5_sel_c1", 32'(sel), 32'h4);
      @(negedge clk);
      rst_n = 1'b0; rd_req = 1'b0;
      #1;
      chk("t5_rst_sel",  32'(sel),  32'h0);
      chk("t5_rst_d",    d,         32'h0);
      chk("t5_rst_rdy",  32'(rdy),  32'h0);
      chk("t5_rst_err",  32'(err),  32'h0);
      chk("t5_rst_ecnt", 32'(ecnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sack = 4'b0100;
      rdy_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rdy) rdy_seen = 1'b1;
      end
      chk("t5_no_rdy", 32'(rdy_seen), 32'h0);
      sack = '0;
      rd_req = 1'b1; addr = 32'h0000_2000; sdata[1] = 32'h0000_0011;
      @(negedge clk);
      chk("t5_sel_new", 32'(sel), 32'h2);
      sack = 4'b0010;
      @(negedge clk);
      chk("t5_rdy_new", 32'(rdy), 32'h1);
      chk("t5_d_new",   d,        32'h0000_0011);
      rd_req = 1'b0; sack = '0;
      @(negedge clk);

      // 6: back-to-back reads with the request held across completion
      rd_req = 1'b1; addr = 32'h0000_2000; sdata[1] = 32'h0000_0022; sdata[0] = 32'h0000_0033;
      @(negedge clk);
      chk("t6_sel_a", 32'(sel), 32'h2);
      sack = 4'b0010;
      @(negedge clk);
      chk("t6_rdy_a", 32'(rdy), 32'h1);
      chk("t6_d_a",   d,        32'h0000_0022);
      addr = 32'h0000_1000; sack = '0;
      @(negedge clk);
      chk("t6_sel_idle", 32'(sel), 32'h0);
      chk("t6_rdy_idle", 32'(rdy), 32'h0);
      @(negedge clk);
      chk("t6_sel_b", 32'(sel), 32'h1);
      sack = 4'b0001;
      @(negedge clk);
      chk("t6_rdy_b", 32'(rdy), 32'h1);
      chk("t6_d_b",   d,        32'h0000_0033);
      chk("t6_err_b", 32'(err), 32'h0);
      rd_req = 1'b0; sack = '0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
